// File: rtl/cam_arbiter.sv
// Round-robin arbiter sharing one CAM port among NUM_REQ requesters.
// Build option CAM_ARB_WRITE_PRIO_EN: pending writes beat searches.
module cam_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_WIDTH   = 32,
  parameter int KEY_DEPTH   = 16,
  parameter int CAM_LATENCY = 1,
  parameter int WR_HOLD     = 1,
  localparam int ADDR_W     = $clog2(KEY_DEPTH),
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]            resp_vld,
  output logic                          resp_hit,
  output logic [ADDR_W-1:0]             resp_addr,
  output logic                          cam_req_vld,
  output logic                          cam_req_we,
  output logic [ADDR_W-1:0]             cam_req_addr,
  output logic [KEY_WIDTH-1:0]          cam_req_data,
  input  logic                          cam_resp_vld,
  input  logic                          cam_resp_hit,
  input  logic [ADDR_W-1:0]             cam_resp_addr
);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           hold_q, hold_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   rdy_q, rdy_d;
  logic                 cvld_q, cvld_d;
  logic                 cwe_q, cwe_d;
  logic [ADDR_W-1:0]    caddr_q, caddr_d;
  logic [KEY_WIDTH-1:0] cdata_q, cdata_d;

  // Tags are kept one-hot: a zero slot marks a write or idle cycle.
  logic [CAM_LATENCY-1:0][NUM_REQ-1:0] tag_q;
  logic [NUM_REQ-1:0]   tail;
  logic [2:0]           flush_q;
  logic                 err_orphan_q;
  logic                 orphan;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [IDX_W-1:0]     win;

  always_comb begin
    int j;
    cand = req_vld & ~rdy_q;
`ifdef CAM_ARB_WRITE_PRIO_EN
    if (|(cand & req_we)) cand = cand & req_we;
`endif
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    rdy_d   = '0;
    cvld_d  = 1'b0;
    cwe_d   = 1'b0;
    caddr_d = '0;
    cdata_d = '0;
    unique case (state_q)
      ARB: begin
        if (found) begin
          rdy_d[win] = 1'b1;
          cvld_d     = 1'b1;
          cwe_d      = req_we[win];
          caddr_d    = req_addr[win*ADDR_W +: ADDR_W];
          cdata_d    = req_data[win*KEY_WIDTH +: KEY_WIDTH];
          rr_d       = (win == IDX_W'(NUM_REQ - 1)) ?
                       '0 : win + 1'b1;
          if (req_we[win] && WR_HOLD > 0) begin
            state_d = HOLD;
            hold_d  = 2'(WR_HOLD);
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - 2'd1;
        if (hold_q <= 2'd1) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      hold_q       <= '0;
      rr_q         <= '0;
      rdy_q        <= '0;
      cvld_q       <= 1'b0;
      cwe_q        <= 1'b0;
      caddr_q      <= '0;
      cdata_q      <= '0;
      tag_q        <= '0;
      flush_q      <= 3'(CAM_LATENCY + 1);
      err_orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rr_q     <= rr_d;
      rdy_q    <= rdy_d;
      cvld_q   <= cvld_d;
      cwe_q    <= cwe_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
      tag_q[0] <= cwe_q ? '0 : rdy_q;
      for (int s = 1; s < CAM_LATENCY; s++)
        tag_q[s] <= tag_q[s-1];
      if (flush_q != '0) flush_q <= flush_q - 3'd1;
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  // Responses to requests cut off by reset may still drain after release.
  assign tail      = tag_q[CAM_LATENCY-1];
  assign orphan    = cam_resp_vld & ~(|tail) & (flush_q == '0);
  assign resp_vld  = cam_resp_vld ? tail : '0;
  assign resp_hit  = cam_resp_vld & (|tail) & cam_resp_hit;
  assign resp_addr = resp_hit ? cam_resp_addr : '0;

  assign req_rdy      = rdy_q;
  assign cam_req_vld  = cvld_q;
  assign cam_req_we   = cwe_q;
  assign cam_req_addr = caddr_q;
  assign cam_req_data = cdata_q;

  assert property (@(posedge clk) disable iff (rst) !err_orphan_q);

endmodule

// File: tb/tb_cam_arbiter.sv
// Scoreboard bench for cam_arbiter with a behavioural CAM on its port.
// Expected order follows CAM_ARB_WRITE_PRIO_EN when defined.
module tb_cam_arbiter;

  localparam int NR  = 4;
  localparam int KW  = 32;
  localparam int KD  = 16;
  localparam int LAT = 1;
  localparam int WH  = 1;
  localparam int AW  = $clog2(KD);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [KW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [NR-1:0] who;
    logic          hit;
    logic [AW-1:0] addr;
    logic [31:0]   cyc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_vld, req_rdy, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*KW-1:0] req_data;
  logic [NR-1:0]    resp_vld;
  logic             resp_hit;
  logic [AW-1:0]    resp_addr;
  logic             cam_req_vld, cam_req_we;
  logic [AW-1:0]    cam_req_addr;
  logic [KW-1:0]    cam_req_data;
  logic             cam_resp_vld, cam_resp_hit;
  logic [AW-1:0]    cam_resp_addr;

  cam_arbiter #(
    .NUM_REQ(NR), .KEY_WIDTH(KW), .KEY_DEPTH(KD),
    .CAM_LATENCY(LAT), .WR_HOLD(WH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data),
    .resp_vld(resp_vld), .resp_hit(resp_hit),
    .resp_addr(resp_addr),
    .cam_req_vld(cam_req_vld), .cam_req_we(cam_req_we),
    .cam_req_addr(cam_req_addr),
    .cam_req_data(cam_req_data),
    .cam_resp_vld(cam_resp_vld),
    .cam_resp_hit(cam_resp_hit),
    .cam_resp_addr(cam_resp_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cmd_t          cmd_q[NR][$];
  exp_t          sb[$];
  int            gnt_log[$];
  int            gnt_cyc[$];
  logic [NR-1:0] hs;
  int            cyc;
  int            n_chk, n_err, n_hit;
  logic [NR-1:0] last_vld;
  logic          last_hit;
  logic [AW-1:0] last_addr;
  logic [KW-1:0] sh_mem[KD];
  logic [KD-1:0] sh_val = '0;
  logic [KW-1:0] cmem[KD];
  logic [KD-1:0] cval = '0;
  logic          inj;

  function automatic logic [AW:0] lookup(
    input logic [KD-1:0] v,
    input logic [KW-1:0] m[KD],
    input logic [KW-1:0] key
  );
    logic [AW:0] r;
    r = '0;
    for (int e = KD - 1; e >= 0; e--)
      if (v[e] && m[e] == key) r = {1'b1, AW'(e)};
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp_v);
    end
  endtask

  // Behavioural CAM: fixed latency, lowest matching entry wins.
  logic [LAT-1:0] m_vld = '0;
  logic [LAT-1:0] m_hit = '0;
  logic [AW-1:0]  m_addr[LAT] = '{default: '0};
  logic [AW:0]    look;

  always_comb look = lookup(cval, cmem, cam_req_data);

  always @(posedge clk) begin
    m_vld[0]  <= cam_req_vld & ~cam_req_we;
    m_hit[0]  <= look[AW];
    m_addr[0] <= look[AW-1:0];
    for (int s = 1; s < LAT; s++) begin
      m_vld[s]  <= m_vld[s-1];
      m_hit[s]  <= m_hit[s-1];
      m_addr[s] <= m_addr[s-1];
    end
    if (cam_req_vld && cam_req_we) begin
      cmem[cam_req_addr] <= cam_req_data;
      cval[cam_req_addr] <= 1'b1;
    end
  end

  assign cam_resp_vld  = m_vld[LAT-1] | inj;
  assign cam_resp_hit  = inj ? 1'b1 : m_hit[LAT-1];
  assign cam_resp_addr = inj ? AW'(7) : m_addr[LAT-1];

  // Monitor: handshakes feed the scoreboard, responses drain it.
  initial begin
    exp_t        e;
    logic [AW:0] r;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("rdy_onehot", 64'($onehot0(req_rdy)), 64'd1);
        for (int i = 0; i < NR; i++) begin
          if (req_vld[i] && req_rdy[i]) begin
            hs[i] = 1'b1;
            gnt_log.push_back(i);
            gnt_cyc.push_back(cyc);
            if (req_we[i]) begin
              sh_mem[req_addr[i*AW +: AW]] = req_data[i*KW +: KW];
              sh_val[req_addr[i*AW +: AW]] = 1'b1;
            end else begin
              r      = lookup(sh_val, sh_mem, req_data[i*KW +: KW]);
              e.who  = NR'(1) << i;
              e.hit  = r[AW];
              e.addr = r[AW-1:0];
              e.cyc  = 32'(cyc + LAT);
              sb.push_back(e);
            end
          end
        end
        if (resp_vld != '0) begin
          last_vld  = resp_vld;
          last_hit  = resp_hit;
          last_addr = resp_addr;
          if (sb.size() == 0) begin
            check("resp_orphan", resp_vld, 0);
          end else begin
            e = sb.pop_front();
            check("resp_who", resp_vld, e.who);
            check("resp_hit", resp_hit, e.hit);
            check("resp_addr", resp_addr, e.addr);
            check("resp_lat", cyc, e.cyc);
            if (e.hit) n_hit++;
          end
        end
      end
    end
  end

  // Requester drivers: hold payload until handshake, then load next.
  initial begin
    cmd_t c;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          req_vld[i] = 1'b0;
          hs[i]      = 1'b0;
        end
        if (!req_vld[i] && cmd_q[i].size() > 0) begin
          c = cmd_q[i].pop_front();
          req_vld[i]          = 1'b1;
          req_we[i]           = c.we;
          req_addr[i*AW +: AW] = c.addr;
          req_data[i*KW +: KW] = c.data;
        end
      end
    end
  end

  task automatic push_cmd(input int i, input logic we,
                          input int a, input logic [KW-1:0] d);
    cmd_t c;
    c.we   = we;
    c.addr = AW'(a);
    c.data = d;
    cmd_q[i].push_back(c);
  endtask

  task automatic clr_log();
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  task automatic clr_reqs();
    for (int i = 0; i < NR; i++) cmd_q[i].delete();
    req_vld = '0;
    hs      = '0;
    sb.delete();
  endtask

  task automatic wait_idle(input string tag);
    int t;
    bit busy;
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
      busy = (req_vld != '0) || (sb.size() != 0);
      for (int i = 0; i < NR; i++)
        if (cmd_q[i].size() != 0) busy = 1'b1;
    end while (busy && t < 300);
    check({tag, "_timeout"}, busy, 0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic chk_gnt(input string tag, input int want[$]);
    check({tag, "_count"}, gnt_log.size(), want.size());
    foreach (want[k])
      check(tag, (k < gnt_log.size()) ? gnt_log[k] : -1, want[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  initial begin
    int want[$];
    int t;
    int w;
    int h0;
    rst      = 1'b1;
    req_vld  = '0;
    req_we   = '0;
    req_addr = '0;
    req_data = '0;
    hs       = '0;
    inj      = 1'b0;
    n_chk    = 0;
    n_err    = 0;
    n_hit    = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_rdy", req_rdy, 0);
    check("rst_cvld", cam_req_vld, 0);
    check("rst_cwe", cam_req_we, 0);
    check("rst_caddr", cam_req_addr, 0);
    check("rst_cdata", cam_req_data, 0);
    check("rst_rvld", resp_vld, 0);
    check("rst_rhit", resp_hit, 0);
    check("rst_raddr", resp_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    #2;

    // All four search continuously
    clr_log();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        push_cmd(i, 1'b0, 0, 32'h1000_0000 + 32'(i * 16 + k));
    wait_idle("t1");
    want = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_gnt("t1_gnt", want);

    // Write vs search, then re-search after the hold
    clr_log();
    h0 = n_hit;
    push_cmd(2, 1'b1, 5, 32'hDEAD_BEEF);
    push_cmd(0, 1'b0, 0, 32'hDEAD_BEEF);
    push_cmd(0, 1'b0, 0, 32'hDEAD_BEEF);
    wait_idle("t2");
`ifdef CAM_ARB_WRITE_PRIO_EN
    want = '{2, 0, 0};
    w    = 0;
    check("t2_hits", n_hit - h0, 2);
`else
    want = '{0, 2, 0};
    w    = 1;
    check("t2_hits", n_hit - h0, 1);
`endif
    chk_gnt("t2_gnt", want);
    check("t2_hold_gap",
          (gnt_cyc.size() > 2) ? gnt_cyc[w+1] - gnt_cyc[w] : -1,
          WH + 1);
    check("t2_last_hit", last_hit, 1);
    check("t2_last_addr", last_addr, 5);

    // Absent key from requester 1
    push_cmd(1, 1'b0, 0, 32'h1234_5678);
    wait_idle("t6");
    check("t6_vld", last_vld, 4'b0010);
    check("t6_hit", last_hit, 0);
    check("t6_addr", last_addr, 0);

    // Reset with searches in flight
    clr_log();
    push_cmd(1, 1'b0, 0, 32'hDEAD_BEEF);
    push_cmd(2, 1'b0, 0, 32'hDEAD_BEEF);
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (gnt_log.size() < 2 && t < 50);
    check("t4_inflight", gnt_log.size() >= 2, 1);
    rst = 1'b1;
    #1;
    check("t4_rdy", req_rdy, 0);
    check("t4_cvld", cam_req_vld, 0);
    check("t4_cdata", cam_req_data, 0);
    check("t4_rvld", resp_vld, 0);
    clr_reqs();
    repeat (2) @(negedge clk);
    clr_log();
    push_cmd(3, 1'b0, 0, 32'hDEAD_BEEF);
    push_cmd(1, 1'b0, 0, 32'hDEAD_BEEF);
    rst = 1'b0;
    @(posedge clk);
    #1;
    inj = 1'b1;
    @(negedge clk);
    #2;
    check("t4_drop_vld", resp_vld, 0);
    check("t4_drop_hit", resp_hit, 0);
    @(posedge clk);
    #1;
    inj = 1'b0;
    wait_idle("t4");
    want = '{1, 3};
    chk_gnt("t4_gnt", want);

    // Lone requester 3, then pointer wrap
    do_reset();
    clr_log();
    push_cmd(3, 1'b0, 0, 32'h0000_0003);
    wait_idle("t3a");
    push_cmd(0, 1'b0, 0, 32'h0000_0010);
    push_cmd(2, 1'b0, 0, 32'h0000_0012);
    wait_idle("t3b");
    want = '{3, 0, 2};
    chk_gnt("t3_gnt", want);

    // Search and write compete from rr_ptr 0
    do_reset();
    clr_log();
    push_cmd(0, 1'b0, 0, 32'hCAFE_F00D);
    push_cmd(1, 1'b1, 3, 32'hCAFE_F00D);
    wait_idle("t5");
`ifdef CAM_ARB_WRITE_PRIO_EN
    want = '{1, 0};
    check("t5_gap",
          (gnt_cyc.size() > 1) ? gnt_cyc[1] - gnt_cyc[0] : -1,
          WH + 1);
    check("t5_hit", last_hit, 1);
`else
    want = '{0, 1};
    check("t5_gap",
          (gnt_cyc.size() > 1) ? gnt_cyc[1] - gnt_cyc[0] : -1,
          1);
    check("t5_hit", last_hit, 0);
`endif
    chk_gnt("t5_gnt", want);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cam_arbiter.md
Name: cam_arbiter

Overview:
Shares one cam/tcam instance between NUM_REQ independent requesters.
- Grants one request per cycle by round-robin and drives the single CAM request port.
- Tags each search and routes the CAM response back to the requester that issued it.
- Enforces a write-to-search hold window so a search issued after a write always sees the updated entry.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_WIDTH, 32, key/data width (matches cam)
KEY_DEPTH, 16, CAM entries; localparam ADDR_W = $clog2(KEY_DEPTH)
CAM_LATENCY, 1, cycles from cam_req_vld (search) to cam_resp_vld (1..4)
WR_HOLD, 1, idle cycles forced after any granted write (0..3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_vld  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester accept; handshake = vld & rdy
req_we  in  NUM_REQ  1 = write entry, 0 = search
req_addr  in  NUM_REQ*ADDR_W  write address (slice i = requester i)
req_data  in  NUM_REQ*KEY_WIDTH  write data / search key
resp_vld  out  NUM_REQ  one-cycle search response pulse to requester i
resp_hit  out  1  search hit (shared bus, qualified by resp_vld)
resp_addr  out  ADDR_W  matching address on hit, 0 on miss
cam_req_vld  out  1  request to CAM
cam_req_we  out  1  write enable to CAM
cam_req_addr  out  ADDR_W  address to CAM
cam_req_data  out  KEY_WIDTH  data/key to CAM
cam_resp_vld  in  1  CAM response valid (search only)
cam_resp_hit  in  1  CAM hit flag
cam_resp_addr  in  ADDR_W  CAM match address

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; state = ARB; hold_cnt = 0; tag pipeline cleared.
- Outputs req_rdy and cam_req_* are registered. A grant decided in cycle N appears on cam_req_* in cycle N+1.
- req_rdy is a one-hot grant: at most one bit set per cycle. The requester must hold vld and payload stable until rdy.
- States:
  - ARB: pick the first requester with req_vld, scanning from rr_ptr upward with wrap modulo NUM_REQ. Assert its req_rdy. Set rr_ptr = winner+1 (wraps NUM_REQ-1 -> 0).
    - If the winner is a write and WR_HOLD > 0: go to HOLD with hold_cnt = WR_HOLD.
  - HOLD: no grants; req_rdy = 0. Decrement hold_cnt each cycle; return to ARB after the cycle in which hold_cnt reaches 1.
- No req_vld in ARB: no grant, rr_ptr unchanged, cam_req_vld = 0 next cycle.
- Tag pipeline:
  - Each issued search shifts the winner index plus a valid bit into a CAM_LATENCY-deep shift register. Writes shift in an invalid slot.
  - On cam_resp_vld, the tag at the pipeline tail selects the resp_vld bit. resp_hit and resp_addr are driven from the CAM the same cycle (combinational pass-through, registered tag).
- Error case: cam_resp_vld with an invalid tail tag drops the response and sets internal sticky err_orphan (simulation assertion).
- Requests are never lost. Requesters have no response backpressure; each must accept resp_vld when it fires.
- Reset mid-operation clears the tag pipeline. Responses arriving later are dropped.

Optional Feature:
CAM_ARB_WRITE_PRIO_EN
- Defined: in ARB, if any requester presents req_vld & req_we, only writers compete (round-robin among them) and searches wait.
- Undefined: pure round-robin regardless of request type.
- rr_ptr update rule is identical in both builds.

Test Plan:
1. NUM_REQ=4, all req_vld=1 (searches) for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3. resp_vld one-hot follows each grant by CAM_LATENCY+1 cycles in the same order.
2. Req 2 writes addr 5, data 0xDEADBEEF; req 0 simultaneously searches 0xDEADBEEF -> grant 0, grant 2, HOLD 1 cycle. A re-issued search from req 0 returns resp_hit=1, resp_addr=5.
3. Only req 3 valid, rr_ptr=0 -> grant 3 immediately, rr_ptr becomes 0 (wrap).
4. rst asserted with 2 searches in flight -> all outputs 0 at once. No resp_vld after release even if the CAM responds; first post-reset grant goes to the lowest valid index.
5. With CAM_ARB_WRITE_PRIO_EN: req 0 search and req 1 write valid, rr_ptr=0 -> req 1 granted first, req 0 after HOLD.
6. Search for an absent key from req 1 -> resp_vld=4'b0010, resp_hit=0, resp_addr=0.
